// File: rtl/spi_flash_responder.sv
// Mode-0 SPI serial-flash target: READ (0x03), JEDEC ID (0x9F) and READ STATUS (0x05),
// with pins synchronized into io_systemClk and data fetched from a byte-wide synchronous memory.
module spi_flash_responder #(
    parameter int          ADDR_W   = 16,
    parameter logic [23:0] JEDEC_ID = 24'hEF4018,
    parameter logic [7:0]  STATUS   = 8'h00
) (
    input  logic              io_systemClk,
    input  logic              systemClk_rstn,
    input  logic              spi_sclk,
    input  logic              spi_ss,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              bad_cmd
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ID, STAT, IGNORE} state_t;

    state_t            state;
    logic              sclk_p0, sclk_p1, sclk_p2;
    logic              ss_p0, ss_p1, ss_p2;
    logic              mosi_p0, mosi_p1;
    logic              sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [4:0]        cnt;
    logic [6:0]        cmd_sr;
    logic [7:0]        cmd_byte;
    logic [ADDR_W-2:0] addr_sr;
    logic [ADDR_W-1:0] addr_next;
    logic [7:0]        tx_byte;
    logic [7:0]        pf_byte;
    logic [7:0]        next_byte;
    logic [1:0]        id_idx;
    logic              mem_vld_p1;

    // Synchronizer stage: ss resets to the asserted level so a frame already in
    // progress when reset releases produces no falling edge and stays dropped.
    always_ff @(posedge io_systemClk) begin
        if (!systemClk_rstn) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            ss_p0   <= 1'b0;
            ss_p1   <= 1'b0;
            ss_p2   <= 1'b0;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            sclk_p0 <= spi_sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            ss_p0   <= spi_ss;
            ss_p1   <= ss_p0;
            ss_p2   <= ss_p1;
            mosi_p0 <= spi_mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign sclk_fall = ~sclk_p1 & sclk_p2;
    assign ss_rise   = ss_p1 & ~ss_p2;
    assign ss_fall   = ~ss_p1 & ss_p2;
    assign cmd_byte  = {cmd_sr, mosi_p1};
    assign addr_next = {addr_sr, mosi_p1};

    always_comb begin
        next_byte = 8'h00;
        case (state)
            DATA: next_byte = pf_byte;
            ID: begin
                case (id_idx)
                    2'd1:    next_byte = JEDEC_ID[15:8];
                    2'd2:    next_byte = JEDEC_ID[7:0];
                    default: next_byte = 8'h00;
                endcase
            end
            STAT:    next_byte = STATUS;
            default: next_byte = 8'h00;
        endcase
    end

    // Protocol stage: cnt counts sampled rises within the current byte; a fall
    // with cnt==0 is the one trailing the command/address byte and shifts nothing.
    always_ff @(posedge io_systemClk) begin
        if (!systemClk_rstn) begin
            state       <= IDLE;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            busy        <= 1'b0;
            bad_cmd     <= 1'b0;
            cnt         <= 5'd0;
            mem_vld_p1  <= 1'b0;
        end else begin
            mem_rd     <= 1'b0;
            bad_cmd    <= 1'b0;
            mem_vld_p1 <= mem_rd;
            if (ss_rise) begin
                state       <= IDLE;
                spi_miso_oe <= 1'b0;
                spi_miso    <= 1'b0;
                busy        <= 1'b0;
                cnt         <= 5'd0;
                mem_vld_p1  <= 1'b0;
            end else if (ss_fall) begin
                state       <= CMD;
                spi_miso_oe <= 1'b1;
                spi_miso    <= 1'b0;
                busy        <= 1'b1;
                cnt         <= 5'd0;
            end else begin
                case (state)
                    CMD: begin
                        if (sclk_rise) begin
                            cmd_sr <= cmd_byte[6:0];
                            cnt    <= cnt + 5'd1;
                            if (cnt == 5'd7) begin
                                cnt <= 5'd0;
                                case (cmd_byte)
                                    8'h03: state <= ADDR;
                                    8'h9F: begin
                                        state    <= ID;
                                        tx_byte  <= JEDEC_ID[23:16];
                                        spi_miso <= JEDEC_ID[23];
                                        id_idx   <= 2'd1;
                                    end
                                    8'h05: begin
                                        state    <= STAT;
                                        tx_byte  <= STATUS;
                                        spi_miso <= STATUS[7];
                                    end
                                    default: begin
                                        state   <= IGNORE;
                                        bad_cmd <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end
                    ADDR: begin
                        if (mem_vld_p1) begin
                            tx_byte  <= mem_rdata;
                            spi_miso <= mem_rdata[7];
                            cnt      <= 5'd0;
                            state    <= DATA;
                        end else if (sclk_rise && cnt != 5'd24) begin
                            addr_sr <= addr_next[ADDR_W-2:0];
                            cnt     <= cnt + 5'd1;
                            if (cnt == 5'd23) begin
                                mem_rd   <= 1'b1;
                                mem_addr <= addr_next;
                            end
                        end
                    end
                    DATA, ID, STAT: begin
                        if (state == DATA && mem_vld_p1)
                            pf_byte <= mem_rdata;
                        if (sclk_rise) begin
                            cnt <= cnt + 5'd1;
                        end else if (sclk_fall) begin
                            if (cnt == 5'd8) begin
                                cnt      <= 5'd0;
                                tx_byte  <= next_byte;
                                spi_miso <= next_byte[7];
                                if (id_idx != 2'd3)
                                    id_idx <= id_idx + 2'd1;
                            end else if (cnt != 5'd0) begin
                                spi_miso <= tx_byte[3'd7 - cnt[2:0]];
                                if (state == DATA && cnt == 5'd1) begin
                                    mem_rd   <= 1'b1;
                                    mem_addr <= mem_addr + ADDR_W'(1);
                                end
                            end
                        end
                    end
                    IGNORE:  spi_miso <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: a mode-0 SPI master task and a frame-level flash model
// check READ, JEDEC ID, STATUS, bad opcodes, aborted frames and mid-frame reset.
`timescale 1ns/1ps
module tb_spi_flash_responder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_ss = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe, mem_rd, busy, bad_cmd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;

    logic [7:0]  mem [0:65535];
    logic [7:0]  mtx [0:15];
    logic [7:0]  mrx [0:15];
    logic [7:0]  exp_rx [0:15];
    logic [15:0] rd_q[$];
    logic [15:0] exp_rd[$];
    int          bad_cnt = 0, exp_bad = 0, consec_err = 0;
    logic        prev_rd = 1'b0;
    logic        oe_mid, busy_mid, oe_end, busy_end, miso_end;
    int          n_pass = 0, n_total = 0;

    spi_flash_responder #(.ADDR_W(16), .JEDEC_ID(24'hEF4018), .STATUS(8'h00)) dut (
        .io_systemClk  (clk),
        .systemClk_rstn(rstn),
        .spi_sclk      (spi_sclk),
        .spi_ss        (spi_ss),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .spi_miso_oe   (spi_miso_oe),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .busy          (busy),
        .bad_cmd       (bad_cmd)
    );

    always #5 clk = ~clk;

    // Synchronous memory plus bus monitors
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata <= mem[mem_addr];
            rd_q.push_back(mem_addr);
        end
        if (bad_cmd) bad_cnt++;
        if (mem_rd && prev_rd) consec_err++;
        prev_rd <= mem_rd;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: sim time limit reached, required $finish before it");
        $fatal(1);
    end

    task automatic xfer(input int nbits, input int div);
        int half;
        half = div * 5;
        #($urandom_range(1, 9));
        spi_ss = 1'b0;
        #(div * 10);
        for (int k = 0; k < nbits; k++) begin
            spi_mosi = mtx[k/8][7-(k%8)];
            #(half);
            spi_sclk = 1'b1;
            mrx[k/8][7-(k%8)] = spi_miso;
            if (k == 0) begin
                oe_mid   = spi_miso_oe;
                busy_mid = busy;
            end
            #(half);
            spi_sclk = 1'b0;
        end
        #(half);
        spi_ss   = 1'b1;
        spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        oe_end   = spi_miso_oe;
        busy_end = busy;
        miso_end = spi_miso;
        #(div * 20);
    endtask

    // Frame-level flash behaviour: what a flash returns for the bytes in mtx
    task automatic model(input int nbits);
        logic [15:0] a, ai;
        int nb, npf;
        nb = nbits / 8;
        exp_rd.delete();
        exp_bad = 0;
        for (int i = 0; i < 16; i++) exp_rx[i] = 8'h00;
        case (mtx[0])
            8'h03: begin
                if (nbits >= 32) begin
                    a   = {mtx[2], mtx[3]};
                    npf = (nbits - 32 + 7) / 8;
                    for (int i = 0; i <= npf; i++) begin
                        ai = a + 16'(i);
                        exp_rd.push_back(ai);
                    end
                    for (int i = 4; i < nb; i++) begin
                        ai = a + 16'(i - 4);
                        exp_rx[i] = mem[ai];
                    end
                end
            end
            8'h9F: begin
                exp_rx[1] = 8'hEF;
                exp_rx[2] = 8'h40;
                exp_rx[3] = 8'h18;
            end
            8'h05: for (int i = 1; i < 16; i++) exp_rx[i] = 8'h00;
            default: if (nbits >= 8) exp_bad = 1;
        endcase
    endtask

    task automatic frame(input int nbits, input int div);
        rd_q.delete();
        bad_cnt = 0;
        for (int i = 0; i < 16; i++) mrx[i] = 8'h00;
        xfer(nbits, div);
        model(nbits);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (5) @(negedge clk);
        n_total++; if (spi_miso !== 1'b0) $display("FAIL reset_miso: got %b want 0", spi_miso); else n_pass++;
        n_total++; if (spi_miso_oe !== 1'b0) $display("FAIL reset_oe: got %b want 0", spi_miso_oe); else n_pass++;
        n_total++; if (mem_rd !== 1'b0) $display("FAIL reset_mem_rd: got %b want 0", mem_rd); else n_pass++;
        n_total++; if (mem_addr !== 16'h0000) $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (bad_cmd !== 1'b0) $display("FAIL reset_bad_cmd: got %b want 0", bad_cmd); else n_pass++;
        rstn = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_read(input int div);
        int nbits;
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 16; i++) mtx[i] = 8'($urandom);
            mtx[0] = 8'h03;
            if (it == 0) begin
                {mtx[1], mtx[2], mtx[3]} = 24'h000010;
                mem[16'h10] = 8'hA1; mem[16'h11] = 8'hB2;
                mem[16'h12] = 8'hC3; mem[16'h13] = 8'hD4;
                nbits = 64;
            end else begin
                nbits = 32 + 8 * $urandom_range(1, 6);
            end
            frame(nbits, div);
            for (int i = 0; i < nbits / 8; i++) begin
                n_total++;
                if (mrx[i] !== exp_rx[i]) $display("FAIL read_byte%0d div%0d: got %h want %h", i, div, mrx[i], exp_rx[i]);
                else n_pass++;
            end
            n_total++;
            if (rd_q.size() != exp_rd.size()) $display("FAIL read_rd_count div%0d: got %0d want %0d", div, rd_q.size(), exp_rd.size());
            else begin
                n_pass++;
                for (int i = 0; i < rd_q.size(); i++) begin
                    n_total++;
                    if (rd_q[i] !== exp_rd[i]) $display("FAIL read_addr%0d div%0d: got %h want %h", i, div, rd_q[i], exp_rd[i]);
                    else n_pass++;
                end
            end
            n_total++; if (oe_mid !== 1'b1 || busy_mid !== 1'b1) $display("FAIL read_oe_busy_mid: got %b%b want 11", oe_mid, busy_mid); else n_pass++;
            n_total++; if (oe_end !== 1'b0 || busy_end !== 1'b0) $display("FAIL read_oe_busy_end: got %b%b want 00", oe_end, busy_end); else n_pass++;
        end
    endtask

    task automatic test_jedec(input int div);
        for (int i = 0; i < 16; i++) mtx[i] = 8'($urandom);
        mtx[0] = 8'h9F;
        frame(48, div);
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (mrx[i] !== exp_rx[i]) $display("FAIL jedec_byte%0d div%0d: got %h want %h", i, div, mrx[i], exp_rx[i]);
            else n_pass++;
        end
        n_total++; if (rd_q.size() != 0) $display("FAIL jedec_no_rd: got %0d reads want 0", rd_q.size()); else n_pass++;
        n_total++; if (bad_cnt != 0) $display("FAIL jedec_bad_cmd: got %0d want 0", bad_cnt); else n_pass++;
    endtask

    task automatic test_wrap(input int div);
        for (int i = 0; i < 16; i++) mtx[i] = 8'($urandom);
        mtx[0] = 8'h03; mtx[2] = 8'hFF; mtx[3] = 8'hFF;
        frame(48, div);
        for (int i = 4; i < 6; i++) begin
            n_total++;
            if (mrx[i] !== exp_rx[i]) $display("FAIL wrap_byte%0d div%0d: got %h want %h", i, div, mrx[i], exp_rx[i]);
            else n_pass++;
        end
        n_total++;
        if (rd_q.size() != exp_rd.size()) $display("FAIL wrap_rd_count div%0d: got %0d want %0d", div, rd_q.size(), exp_rd.size());
        else begin
            n_pass++;
            for (int i = 0; i < rd_q.size(); i++) begin
                n_total++;
                if (rd_q[i] !== exp_rd[i]) $display("FAIL wrap_addr%0d div%0d: got %h want %h", i, div, rd_q[i], exp_rd[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_bad_cmd(input int div);
        for (int i = 0; i < 16; i++) mtx[i] = 8'($urandom);
        mtx[0] = 8'hAB;
        frame(32, div);
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (mrx[i] !== exp_rx[i]) $display("FAIL bad_byte%0d div%0d: got %h want %h", i, div, mrx[i], exp_rx[i]);
            else n_pass++;
        end
        n_total++; if (bad_cnt != exp_bad) $display("FAIL bad_pulses div%0d: got %0d want %0d", div, bad_cnt, exp_bad); else n_pass++;
        n_total++; if (rd_q.size() != 0) $display("FAIL bad_no_rd: got %0d reads want 0", rd_q.size()); else n_pass++;
        mtx[0] = 8'h05;
        frame(24, div);
        for (int i = 1; i < 3; i++) begin
            n_total++;
            if (mrx[i] !== exp_rx[i]) $display("FAIL status_byte%0d div%0d: got %h want %h", i, div, mrx[i], exp_rx[i]);
            else n_pass++;
        end
        n_total++; if (bad_cnt != 0) $display("FAIL status_bad_cmd: got %0d want 0", bad_cnt); else n_pass++;
    endtask

    task automatic test_abort(input int div);
        for (int i = 0; i < 16; i++) mtx[i] = 8'($urandom);
        mtx[0] = 8'h03;
        frame(43, div);
        for (int i = 4; i < 5; i++) begin
            n_total++;
            if (mrx[i] !== exp_rx[i]) $display("FAIL abort_byte%0d div%0d: got %h want %h", i, div, mrx[i], exp_rx[i]);
            else n_pass++;
        end
        n_total++; if (oe_end !== 1'b0 || busy_end !== 1'b0 || miso_end !== 1'b0)
            $display("FAIL abort_end: got oe/busy/miso %b%b%b want 000", oe_end, busy_end, miso_end); else n_pass++;
        n_total++;
        if (rd_q.size() != exp_rd.size()) $display("FAIL abort_rd_count div%0d: got %0d want %0d", div, rd_q.size(), exp_rd.size());
        else begin
            n_pass++;
            for (int i = 0; i < rd_q.size(); i++) begin
                n_total++;
                if (rd_q[i] !== exp_rd[i]) $display("FAIL abort_addr%0d div%0d: got %h want %h", i, div, rd_q[i], exp_rd[i]);
                else n_pass++;
            end
        end
        for (int i = 0; i < 16; i++) mtx[i] = 8'($urandom);
        mtx[0] = 8'h03; {mtx[1], mtx[2], mtx[3]} = 24'h000020;
        frame(48, div);
        for (int i = 4; i < 6; i++) begin
            n_total++;
            if (mrx[i] !== exp_rx[i]) $display("FAIL after_abort_byte%0d div%0d: got %h want %h", i, div, mrx[i], exp_rx[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid(input int div);
        for (int i = 0; i < 16; i++) mtx[i] = 8'($urandom);
        mtx[0] = 8'h03;
        rd_q.delete();
        bad_cnt = 0;
        fork
            xfer(64, div);
            begin
                #(div * 10 * 42);
                @(negedge clk) rstn = 1'b0;
                @(negedge clk) rstn = 1'b1;
                n_total++; if ({spi_miso, spi_miso_oe, mem_rd, busy, bad_cmd} !== 5'b0 || mem_addr !== 16'h0)
                    $display("FAIL midrst_outputs: got miso/oe/rd/busy/bad %b addr %h want 00000 addr 0000",
                             {spi_miso, spi_miso_oe, mem_rd, busy, bad_cmd}, mem_addr);
                else n_pass++;
                rd_q.delete();
                #(div * 10 * 8);
                n_total++; if (spi_miso_oe !== 1'b0 || busy !== 1'b0)
                    $display("FAIL midrst_dropped: got oe/busy %b%b want 00", spi_miso_oe, busy);
                else n_pass++;
            end
        join
        n_total++; if (rd_q.size() != 0) $display("FAIL midrst_no_rd: got %0d reads want 0", rd_q.size()); else n_pass++;
        for (int i = 0; i < 16; i++) mtx[i] = 8'($urandom);
        mtx[0] = 8'h03;
        frame(56, div);
        for (int i = 0; i < 7; i++) begin
            n_total++;
            if (mrx[i] !== exp_rx[i]) $display("FAIL midrst_next_byte%0d div%0d: got %h want %h", i, div, mrx[i], exp_rx[i]);
            else n_pass++;
        end
    endtask

    initial begin
        int divs[2];
        divs[0] = 8;
        divs[1] = 16;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        test_reset();
        for (int d = 0; d < 2; d++) begin
            test_read(divs[d]);
            test_jedec(divs[d]);
            test_wrap(divs[d]);
            test_bad_cmd(divs[d]);
            test_abort(divs[d]);
            test_reset_mid(divs[d]);
        end
        n_total++; if (consec_err != 0) $display("FAIL mem_rd_back_to_back: got %0d occurrences want 0", consec_err); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
